// File: rtl/ctrl_int.sv
// ctrl_int: interrupt sequencer for the stack-based CPU.
// Latches rising edges on irq, picks the lowest eligible index at an
// instruction boundary, then walks the datapath through
// SAVE (push PC) -> VECTOR (jump) -> SERVICE -> RESTORE (pop PC).
// Optional build macro: CTRL_INT_WDOG_EN adds a service-timeout watchdog.
module ctrl_int #(
    parameter int                N_IRQ      = 4,
    parameter int                VEC_W      = 10,
    parameter logic [VEC_W-1:0]  VEC_BASE   = 10'h3C0,
    parameter int                VEC_STRIDE = 4,
    parameter int                WDOG_CYC   = 255
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_IRQ-1:0]   irq,
    input  logic               mask_we,
    input  logic [N_IRQ-1:0]   mask_din,
    input  logic               boundary,
    input  logic               reti,
    output logic               stall,
    output logic               push_int,
    output logic               pop_int,
    output logic               s_vec,
    output logic [VEC_W-1:0]   vec,
    output logic [N_IRQ-1:0]   irq_ack,
    output logic               in_service,
    output logic [2:0]         active_id,
    output logic               wdog_err
);

    typedef enum logic [2:0] {IDLE, SAVE, VECTOR, SERVICE, RESTORE} state_t;

    state_t             state_q;
    logic [N_IRQ-1:0]   irq_dly_q;
    logic [N_IRQ-1:0]   pend_q, pend_d;
    logic [N_IRQ-1:0]   mask_q;
    logic [N_IRQ-1:0]   elig;
    logic [N_IRQ-1:0]   id_oh;
    logic [2:0]         sel_id;
    logic [2:0]         active_id_q;
    logic               stall_q, push_q, pop_q, svec_q, insvc_q;
    logic [N_IRQ-1:0]   ack_q;
    logic               wd_to;

    assign elig = pend_q & ~mask_q;

    // Fixed priority: lowest eligible index wins, and the one-hot of the active line
    always_comb begin
        sel_id = 3'd0;
        for (int i = N_IRQ - 1; i >= 0; i--)
            if (elig[i]) sel_id = 3'(i);
        id_oh = '0;
        for (int i = 0; i < N_IRQ; i++)
            id_oh[i] = (active_id_q == 3'(i));
    end

    // A fresh edge beats the acknowledge clear of the same bit
    always_comb begin
        pend_d = (pend_q & ~ack_q) | (irq & ~irq_dly_q);
    end

    // Edge-capture history, pending latch and mask register
    always_ff @(posedge clk) begin
        if (!reset) begin
            irq_dly_q <= '0;
            pend_q    <= '0;
            mask_q    <= '1;
        end else begin
            irq_dly_q <= irq;
            pend_q    <= pend_d;
            if (mask_we) mask_q <= mask_din;
        end
    end

`ifdef CTRL_INT_WDOG_EN
    localparam int WD_W = ($clog2(WDOG_CYC + 1) > 8) ? $clog2(WDOG_CYC + 1) : 8;
    logic [WD_W-1:0] wd_cnt_q;
    logic            wdog_err_q;

    // Timeout fires on the WDOG_CYC-th SERVICE cycle; a coincident reti takes precedence
    assign wd_to = (state_q == SERVICE) && !reti && (wd_cnt_q == WD_W'(WDOG_CYC - 1));

    // Service-cycle counter and sticky timeout flag
    always_ff @(posedge clk) begin
        if (!reset) begin
            wd_cnt_q   <= '0;
            wdog_err_q <= 1'b0;
        end else begin
            if (state_q == SERVICE) wd_cnt_q <= wd_cnt_q + 1'b1;
            else                    wd_cnt_q <= '0;
            if (wd_to) wdog_err_q <= 1'b1;
        end
    end

    assign wdog_err = wdog_err_q;
`else
    assign wd_to    = 1'b0;
    assign wdog_err = 1'b0;
`endif

    // Sequencer FSM; each output register is loaded with the value for the state being entered
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            active_id_q <= 3'd0;
            stall_q     <= 1'b0;
            push_q      <= 1'b0;
            pop_q       <= 1'b0;
            svec_q      <= 1'b0;
            ack_q       <= '0;
            insvc_q     <= 1'b0;
        end else begin
            stall_q <= 1'b0;
            push_q  <= 1'b0;
            pop_q   <= 1'b0;
            svec_q  <= 1'b0;
            ack_q   <= '0;
            insvc_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if ((|elig) && boundary) begin
                        state_q     <= SAVE;
                        active_id_q <= sel_id;
                        stall_q     <= 1'b1;
                        push_q      <= 1'b1;
                    end
                end
                SAVE: begin
                    state_q <= VECTOR;
                    stall_q <= 1'b1;
                    svec_q  <= 1'b1;
                    ack_q   <= id_oh;
                end
                VECTOR: begin
                    state_q <= SERVICE;
                    insvc_q <= 1'b1;
                end
                SERVICE: begin
                    insvc_q <= 1'b1;
                    if (reti || wd_to) begin
                        state_q <= RESTORE;
                        stall_q <= 1'b1;
                        pop_q   <= 1'b1;
                    end
                end
                RESTORE: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign stall      = stall_q;
    assign push_int   = push_q;
    assign pop_int    = pop_q;
    assign s_vec      = svec_q;
    assign irq_ack    = ack_q;
    assign in_service = insvc_q;
    assign active_id  = active_id_q;
    assign vec        = VEC_BASE + VEC_W'(active_id_q) * VEC_W'(VEC_STRIDE);

endmodule
